// File: rtl/path_move_decoder.sv
// path_move_decoder
//   Consumer end of the maze solver's path output. Each accepted {X,Y}
//   coordinate is compared with the previous one. A unit step becomes a
//   2-bit direction code (0=up Y+1, 1=right X+1, 2=left X-1, 3=down Y-1),
//   and that code is queued in a small FIFO for downstream logic. The
//   block also checks that the path is legal: correct start cell, unit
//   adjacency with no border wrap, and at most 255 steps.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle pulse: flush everything and expect a new path
//   in_valid/in_data  coordinate stream {X[3:0],Y[3:0]}
//   in_ready          coordinate accepted when in_valid && in_ready
//   dir_valid/dir     FIFO head (direction code)
//   dir_ready         consumer pops the head when dir_valid && dir_ready
//   busy              expecting coordinates (FIRST or RUN)
//   done              goal reached and FIFO drained
//   error/err_code    sticky path error: 1 bad start, 2 non-adjacent, 3 overflow
//   step_count        direction codes produced for the current path
module path_move_decoder #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [7:0]  START_COORD = 8'h00,
  parameter logic [7:0]  GOAL_COORD  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       dir_valid,
  output logic [1:0] dir,
  input  logic       dir_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] step_count
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nx;

  logic [7:0] prev, prev_nx;
  logic [7:0] step_nx;
  logic [1:0] err_nx;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_full, fifo_empty;
  logic          push, pop, flush, accept;

  logic signed [4:0] dx, dy;
  logic              step_ok;
  logic [1:0]        step_code;

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);

  // Full is taken from the count register, so a pop in this cycle does not
  // reopen in_ready until the following cycle.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_FIRST: in_ready = 1'b1;
      S_RUN:   in_ready = !fifo_full;
      default: in_ready = 1'b0;
    endcase
  end

  // start wins over a same-cycle handshake; that coordinate is dropped.
  assign accept = in_valid && in_ready && !start;

  assign dir_valid = !fifo_empty && (state != S_ERR) && (state != S_IDLE);
  assign dir       = dir_valid ? mem[rd_ptr] : 2'd0;
  assign pop       = dir_valid && dir_ready;

  assign busy  = (state == S_FIRST) || (state == S_RUN);
  assign done  = (state == S_DONE) && fifo_empty;
  assign error = (state == S_ERR);

  // Deltas are 5-bit signed so that 15 <-> 0 shows up as +/-15, not +/-1.
  assign dx = $signed({1'b0, in_data[7:4]}) - $signed({1'b0, prev[7:4]});
  assign dy = $signed({1'b0, in_data[3:0]}) - $signed({1'b0, prev[3:0]});

  always_comb begin
    step_ok   = 1'b1;
    step_code = 2'd0;
    if (dx == 5'sd0 && dy == 5'sd1)
      step_code = 2'd0;
    else if (dx == 5'sd1 && dy == 5'sd0)
      step_code = 2'd1;
    else if (dx == -5'sd1 && dy == 5'sd0)
      step_code = 2'd2;
    else if (dx == 5'sd0 && dy == -5'sd1)
      step_code = 2'd3;
    else
      step_ok = 1'b0;
  end

  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    step_nx  = step_count;
    err_nx   = err_code;
    push     = 1'b0;
    flush    = 1'b0;
    if (start) begin
      state_nx = S_FIRST;
      flush    = 1'b1;
      step_nx  = '0;
      err_nx   = '0;
    end else begin
      case (state)
        S_FIRST: begin
          if (accept) begin
            if (in_data == START_COORD) begin
              prev_nx  = in_data;
              state_nx = (START_COORD == GOAL_COORD) ? S_DONE : S_RUN;
            end else begin
              state_nx = S_ERR;
              err_nx   = 2'd1;
              flush    = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (!step_ok) begin
              state_nx = S_ERR;
              err_nx   = 2'd2;
              flush    = 1'b1;
            end else if (step_count == 8'hFF) begin
              state_nx = S_ERR;
              err_nx   = 2'd3;
              flush    = 1'b1;
            end else begin
              push    = 1'b1;
              step_nx = step_count + 8'd1;
              prev_nx = in_data;
              if (in_data == GOAL_COORD)
                state_nx = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      prev       <= '0;
      step_count <= '0;
      err_code   <= '0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      step_count <= step_nx;
      err_code   <= err_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= step_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/path_move_decoder.md
Name: path_move_decoder

Overview:
Consumer end of the maze solver's path output. Accepts the solver's path as a stream of packed {X[3:0],Y[3:0]} coordinates from start cell to goal cell. Decodes each step into a 2-bit direction code using the solver's neighbour-order encoding, and buffers the codes in a small FIFO for the downstream motion/display logic. Also checks path legality: start cell, unit adjacency, no border wrap, and length.

Parameters:
FIFO_DEPTH, 4, direction FIFO entries (power of two, >=2)
START_COORD, 8'h00, required first coordinate
GOAL_COORD, 8'hFF, coordinate that terminates the path

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse: clear state, begin new path
in_valid  in  1  coordinate offered
in_data  in  8  coordinate {X,Y}
in_ready  out  1  coordinate accepted when in_valid&&in_ready
dir_valid  out  1  FIFO head valid
dir  out  2  direction: 0=up(Y+1) 1=right(X+1) 2=left(X-1) 3=down(Y-1)
dir_ready  in  1  consumer pops head when dir_valid&&dir_ready
busy  out  1  state is FIRST or RUN
done  out  1  level: goal reached and FIFO drained
error  out  1  level, sticky until start/rst
err_code  out  2  0 none, 1 bad start, 2 non-adjacent step, 3 length overflow
step_count  out  8  number of direction codes produced for current path

Behaviour:
- Reset: state IDLE; FIFO empty; prev coordinate 8'h00; step_count 0; in_ready, dir_valid, busy, done, error 0; err_code 0; dir 0.
- States: IDLE, FIRST, RUN, DONE, ERR.
- start, any state, including mid-path: next cycle state FIRST. FIFO flushed, step_count 0, error/err_code cleared. start has priority over a same-cycle handshake; that coordinate is discarded.
- FIRST: in_ready=1. On accept:
  - in_data==START_COORD: store as prev; go to RUN. If START_COORD==GOAL_COORD, go to DONE instead.
  - Otherwise: go to ERR, err_code=1.
- RUN: in_ready = !fifo_full. The full flag is registered; a same-cycle pop does not open in_ready. On accept, compute dX, dY as signed 5-bit differences, with no 4-bit wrap:
  - dY=+1,dX=0 -> 0; dX=+1,dY=0 -> 1; dX=-1,dY=0 -> 2; dY=-1,dX=0 -> 3.
  - Any other delta: ERR, err_code=2. This covers a repeated cell, a diagonal, a jump, or 15<->0 wrap.
  - Legal step with step_count==255: ERR, err_code=3, nothing pushed.
  - Otherwise: push code, step_count+1, prev<=in_data. If in_data==GOAL_COORD, go to DONE.
- DONE: in_ready=0; FIFO continues draining. done=1 when state DONE and FIFO empty. Stays until start.
- ERR: in_ready=0; FIFO flushed on entry; dir_valid=0; error=1. Stays until start/rst.
- IDLE: in_ready=0, dir_valid=0. in_valid is ignored in IDLE, DONE and ERR.
- FIFO: synchronous push/pop with independent pointers and a count register.
  - A pushed code is visible at dir_valid/dir one cycle after the accepting edge.
  - Simultaneous push and pop when not full is legal; count is unchanged.
  - A pop with FIFO empty is ignored.
  - dir holds the head value and is stable while dir_valid&&!dir_ready.
- step_count is 8-bit and never wraps (overflow is an error).

Test Plan:
- Legal path: start; stream 00,01,11,12,…; final step E,F->F,F (code 1); dir_ready=1. Required: codes 0,1,0,… match deltas; step_count equals accepted coordinates minus 1; done=1 one cycle after last pop; error=0.
- Bad start: start; first coordinate 8'h10. Required: next cycle error=1, err_code=1, in_ready=0, dir_valid=0; a further start clears error.
- Border wrap and repeat: path 00,01,F1. Required: err_code=2 after third accept, FIFO flushed (dir_valid=0). Separately, path 00,01,01 gives err_code=2.
- Backpressure: FIFO_DEPTH=4, dir_ready=0, stream 00,01,02,03,04,05. Required: in_ready=0 after 4 codes; coordinate 05 held. Raise dir_ready: codes pop in order 0,0,0,0,0; 05 is accepted the cycle after the first pop.
- Restart mid-path: after 00,01,02 with 2 codes buffered, pulse start while in_valid=1 with 03. Required: 03 discarded, FIFO empty, step_count=0, state FIRST; a new path starting 00 decodes normally.
- Async reset mid-RUN with FIFO non-empty: assert rst between clock edges. Required: all outputs at reset values immediately, without waiting for a clock edge.
